// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: big-endian byte lanes over a req/ack bus, IDLE/BUSY/DONE FSM.
// Optional misaligned-access trap is built when LSU_ALIGN_CHK_EN is defined.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        whilo_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
`ifdef LSU_ALIGN_CHK_EN
    output logic        align_err_o,
`endif
    output logic        stall_req_o
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned OP_W   = 8;

    localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_W-1:0]    wd_q, wd_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]   load_buf_q, load_buf_d;

    logic                is_mem_c;
    logic                req_we_c;
    logic [SEL_W-1:0]    req_sel_c;
    logic [DATA_W-1:0]   req_wdata_c;
    logic                misalign_c;
    logic [7:0]          ld_byte_c;
    logic [15:0]         ld_half_c;
    logic [DATA_W-1:0]   ld_data_c;

    // Decode the incoming op into bus lane select and replicated store data.
    always_comb begin
        is_mem_c    = 1'b0;
        req_we_c    = 1'b0;
        req_sel_c   = '0;
        req_wdata_c = reg2_i;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP: begin
                is_mem_c  = 1'b1;
                req_sel_c = SEL_W'(4'b1000 >> mem_addr_i[1:0]);
            end
            EXE_SB_OP: begin
                is_mem_c    = 1'b1;
                req_we_c    = 1'b1;
                req_sel_c   = SEL_W'(4'b1000 >> mem_addr_i[1:0]);
                req_wdata_c = {4{reg2_i[7:0]}};
            end
            EXE_LH_OP, EXE_LHU_OP: begin
                is_mem_c  = 1'b1;
                req_sel_c = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            end
            EXE_SH_OP: begin
                is_mem_c    = 1'b1;
                req_we_c    = 1'b1;
                req_sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                req_wdata_c = {2{reg2_i[15:0]}};
            end
            EXE_LW_OP: begin
                is_mem_c  = 1'b1;
                req_sel_c = 4'b1111;
            end
            EXE_SW_OP: begin
                is_mem_c  = 1'b1;
                req_we_c  = 1'b1;
                req_sel_c = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef LSU_ALIGN_CHK_EN
    logic align_err_q, align_err_d;

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    always_comb begin
        misalign_c = 1'b0;
        case (aluop_i)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: misalign_c = mem_addr_i[0];
            EXE_LW_OP, EXE_SW_OP:             misalign_c = (mem_addr_i[1:0] != 2'b00);
            default:                          misalign_c = 1'b0;
        endcase
    end

    assign align_err_o = align_err_q;
`else
    assign misalign_c = 1'b0;
`endif

    // Extract and extend the addressed lane from the captured read word.
    always_comb begin
        case (addr_lo_q)
            2'b00:   ld_byte_c = load_buf_q[31:24];
            2'b01:   ld_byte_c = load_buf_q[23:16];
            2'b10:   ld_byte_c = load_buf_q[15:8];
            default: ld_byte_c = load_buf_q[7:0];
        endcase
        ld_half_c = addr_lo_q[1] ? load_buf_q[15:0] : load_buf_q[31:16];
        case (op_q)
            EXE_LB_OP:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            EXE_LBU_OP: ld_data_c = {24'h0, ld_byte_c};
            EXE_LH_OP:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
            EXE_LHU_OP: ld_data_c = {16'h0, ld_half_c};
            default:    ld_data_c = load_buf_q;
        endcase
    end

    // Next-state and MEM/WB-facing outputs.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        op_d        = op_q;
        wd_d        = wd_q;
        addr_lo_d   = addr_lo_q;
        load_buf_d  = load_buf_q;
`ifdef LSU_ALIGN_CHK_EN
        align_err_d = 1'b0;
`endif
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        whilo_o     = whilo_i;
        stall_req_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_mem_c) begin
                    wreg_o  = 1'b0;
                    whilo_o = 1'b0;
                    if (misalign_c) begin
`ifdef LSU_ALIGN_CHK_EN
                        align_err_d = 1'b1;
`endif
                    end else begin
                        stall_req_o = 1'b1;
                        state_d     = BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we_c;
                        bus_addr_d  = {mem_addr_i[31:2], 2'b00};
                        bus_sel_d   = req_sel_c;
                        bus_wdata_d = req_wdata_c;
                        op_d        = aluop_i;
                        wd_d        = wd_i;
                        addr_lo_d   = mem_addr_i[1:0];
                    end
                end
            end
            BUSY: begin
                stall_req_o = 1'b1;
                wreg_o      = 1'b0;
                whilo_o     = 1'b0;
                if (bus_ack_i) begin
                    bus_req_d  = 1'b0;
                    load_buf_d = bus_rdata_i;
                    state_d    = DONE;
                end
            end
            DONE: begin
                wd_o    = wd_q;
                wreg_o  = ~bus_we_q;
                if (!bus_we_q) begin
                    wdata_o = ld_data_c;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            op_q        <= '0;
            wd_q        <= '0;
            addr_lo_q   <= '0;
            load_buf_q  <= '0;
`ifdef LSU_ALIGN_CHK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            op_q        <= op_d;
            wd_q        <= wd_d;
            addr_lo_q   <= addr_lo_d;
            load_buf_q  <= load_buf_d;
`ifdef LSU_ALIGN_CHK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule
